vcve2_ex_seq: RTL and testbench
===============================

# vcve2_ex_seq

Execution-stage sequencer for the counterpart side of the EX block's multi-cycle interface. Accepts one operation at a time from the decoder, drives the dynamic enables, static selects and first-cycle flag into the EX block, and owns the two 34-bit intermediate-value registers that the EX block writes. It waits for EX-valid, buffers the result for writeback, and supports flush and a watchdog abort. It sits between ID/decoder control and the EX block.

## Interface
- RV32M, vcve2_pkg::RV32MFast, multiplier/divider configuration; RV32MNone disables mult/div selects
- TimeoutCycles, 40, maximum EXEC cycles before abort; legal range 2..63
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- issue_valid_i  in  1  decoder presents an operation
- issue_ready_o  out  1  sequencer accepts the operation this cycle
- issue_mult_i / issue_div_i  in  1 each  operation class; both low means ALU; both high is illegal
- flush_i  in  1  kill any in-flight operation
- mult_en_o / div_en_o  out  1 each  dynamic enables to EX
- mult_sel_o / div_sel_o  out  1 each  static selects to EX
- alu_instr_first_cycle_o  out  1  first EXEC cycle flag
- imd_val_we_i  in  2  intermediate write enables from EX
- imd_val_d_i  in  2x34  intermediate write data from EX
- imd_val_q_o  out  2x34  intermediate register contents to EX
- ex_valid_i  in  1  EX result valid
- result_ex_i  in  32  EX result
- wb_valid_o  out  1  buffered result available
- wb_ready_i  in  1  writeback consumes the result
- wb_result_o  out  32  buffered result
- exec_cycles_o  out  6  EXEC cycle count of the current or last operation
- err_timeout_o  out  1  one-cycle pulse when the watchdog aborts

## Operation
- States: IDLE, EXEC, WAIT_WB.
- issue_ready_o = (state==IDLE) & ~flush_i.
- Accept on issue_valid_i & issue_ready_o:
  - Latch the class (mult/div sel regs; forced 0 when RV32M==RV32MNone).
  - Clear exec_cycles_o.
  - Transition to EXEC.
- EXEC:
  - mult_en_o = mult_sel_o & ~flush_i; div_en_o likewise.
  - alu_instr_first_cycle_o = 1 only in the first EXEC cycle.
  - exec_cycles_o increments each EXEC cycle and saturates at 63.
  - imd_val_q_o[k] <= imd_val_d_i[k] when imd_val_we_i[k] & state==EXEC. Writes in other states are ignored.
- ex_valid_i in EXEC (first cycle allowed):
  - wb_result_o <= result_ex_i.
  - Transition to WAIT_WB.
- WAIT_WB:
  - wb_valid_o=1; enables are 0; selects are held.
  - On wb_ready_i, go to IDLE; selects clear to 0 there.
- Watchdog: if the EXEC cycle count reaches TimeoutCycles without ex_valid_i:
  - Pulse err_timeout_o.
  - Go to IDLE; no writeback.
- flush_i, highest priority, from any state:
  - Next state is IDLE.
  - wb_valid_o and selects are 0 the next cycle.
  - Enables are gated combinationally in the same cycle.
  - flush_i beats ex_valid_i and timeout in the same cycle; no err_timeout_o pulse.
- Illegal issue_mult_i & issue_div_i: treated as mult.
- Intermediate registers are never cleared except by reset. EX initialises them in the first cycle.

## Timing
- Reset values:
  - state IDLE; all outputs 0 except issue_ready_o=1.
  - imd_val_q_o both 0; wb_result_o 0; exec_cycles_o 0.
- Accept in cycle N gives EXEC and first-cycle flag in N+1.
- ex_valid_i in cycle M gives wb_valid_o in M+1.
- Minimum issue-to-issue spacing is 3 cycles (IDLE, EXEC, WAIT_WB with wb_ready_i high).
- Intermediate writes are visible on imd_val_q_o the cycle after the write enable.
- Reset mid-operation: immediate return to reset values; no writeback.

## Structure
- vcve2_pkg gains the ex_seq_state_e enum (IDLE, EXEC, WAIT_WB).
- vcve2_pkg gains the constant ExSeqCntW = 6.
- Single sub-module vcve2_imd_val_reg holds the 2x34 intermediate registers: per-entry write enable, async reset.
- FSM, counter and writeback buffer live in the top module.

## Test plan
- ALU op with ex_valid_i in the first EXEC cycle, result 0x1234_5678:
  - alu_instr_first_cycle_o high for 1 cycle.
  - wb_valid_o next cycle with 0x1234_5678.
  - exec_cycles_o=1.
- Slow-div stub asserting imd_val_we_i=2'b11 each cycle and ex_valid_i at cycle 37:
  - div_en_o high for exactly 37 cycles.
  - imd_val_q_o tracks imd_val_d_i one cycle later.
  - exec_cycles_o=37.
- flush_i at EXEC cycle 10 of a div:
  - div_en_o low the same cycle; IDLE next cycle.
  - No wb_valid_o; issue accepted 1 cycle after flush deasserts.
- Writeback backpressure: wb_ready_i low for 5 cycles.
  - wb_valid_o and wb_result_o stable.
  - issue_ready_o low throughout; IDLE the cycle after wb_ready_i.
- ex_valid_i never asserted, TimeoutCycles=40:
  - err_timeout_o pulses once, at EXEC cycle 40.
  - Then IDLE, no wb_valid_o.
- RV32M=RV32MNone with issue_mult_i=1:
  - mult_sel_o and mult_en_o stay 0.
  - Operation completes as ALU on ex_valid_i.

Source files
------------

// File: rtl/vcve2_pkg.sv
// vcve2_pkg: shared types and constants for the vcve2 execution-stage sequencer.
//   rv32m_e         multiplier/divider configuration selector
//   ex_seq_state_e  sequencer FSM states (IDLE, EXEC, WAIT_WB)
//   ExSeqCntW       width of the EXEC-cycle counter
//   imd_val_t       one 34-bit intermediate value shared with the EX block
//   sat_inc()       saturating increment for the EXEC-cycle counter
package vcve2_pkg;

  typedef enum integer {
    RV32MNone        = 0,
    RV32MSlow        = 1,
    RV32MFast        = 2,
    RV32MSingleCycle = 3
  } rv32m_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXEC    = 2'd1,
    WAIT_WB = 2'd2
  } ex_seq_state_e;

  localparam int unsigned ExSeqCntW = 6;
  localparam int unsigned ImdValW   = 34;
  localparam int unsigned ExResultW = 32;

  typedef logic [ImdValW-1:0]   imd_val_t;
  typedef logic [ExSeqCntW-1:0] ex_seq_cnt_t;
  typedef logic [ExResultW-1:0] ex_result_t;

  // Counts up and sticks at all-ones.
  function automatic ex_seq_cnt_t sat_inc(input ex_seq_cnt_t cnt);
    return (&cnt) ? cnt : cnt + ex_seq_cnt_t'(1);
  endfunction

endpackage

// File: rtl/vcve2_ex_seq_if.sv
// vcve2_ex_seq_if: signal bundle between the sequencer and its neighbours
// (decoder issue port, EX block control/intermediate/result port, writeback port).
//   slave  : the sequencer's view (vcve2_ex_seq)
//   master : the surrounding pipeline's view (decoder, EX block, writeback)
interface vcve2_ex_seq_if;
  import vcve2_pkg::*;

  // Decoder issue handshake
  logic                 issue_valid_i;
  logic                 issue_ready_o;
  logic                 issue_mult_i;
  logic                 issue_div_i;
  logic                 flush_i;

  // Control into the EX block
  logic                 mult_en_o;
  logic                 div_en_o;
  logic                 mult_sel_o;
  logic                 div_sel_o;
  logic                 alu_instr_first_cycle_o;

  // Intermediate-value registers owned by the sequencer
  logic     [1:0]       imd_val_we_i;
  imd_val_t [1:0]       imd_val_d_i;
  imd_val_t [1:0]       imd_val_q_o;

  // EX result and writeback buffer
  logic                 ex_valid_i;
  ex_result_t           result_ex_i;
  logic                 wb_valid_o;
  logic                 wb_ready_i;
  ex_result_t           wb_result_o;

  // Status
  ex_seq_cnt_t          exec_cycles_o;
  logic                 err_timeout_o;

  modport slave (
    input  issue_valid_i, issue_mult_i, issue_div_i, flush_i,
    input  imd_val_we_i, imd_val_d_i, ex_valid_i, result_ex_i, wb_ready_i,
    output issue_ready_o, mult_en_o, div_en_o, mult_sel_o, div_sel_o,
    output alu_instr_first_cycle_o, imd_val_q_o, wb_valid_o, wb_result_o,
    output exec_cycles_o, err_timeout_o
  );

  modport master (
    output issue_valid_i, issue_mult_i, issue_div_i, flush_i,
    output imd_val_we_i, imd_val_d_i, ex_valid_i, result_ex_i, wb_ready_i,
    input  issue_ready_o, mult_en_o, div_en_o, mult_sel_o, div_sel_o,
    input  alu_instr_first_cycle_o, imd_val_q_o, wb_valid_o, wb_result_o,
    input  exec_cycles_o, err_timeout_o
  );

endinterface

// File: rtl/vcve2_imd_val_reg.sv
// vcve2_imd_val_reg: the two 34-bit intermediate-value registers the EX block
// uses across multi-cycle operations. Each entry has its own write enable.
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   we_i[k]        write entry k with d_i[k] at the next rising edge
//   d_i            write data
//   q_o            current register contents
module vcve2_imd_val_reg
  import vcve2_pkg::*;
(
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic     [1:0] we_i,
  input  imd_val_t [1:0] d_i,
  output imd_val_t [1:0] q_o
);

  // NOTE: non-blocking (<=) in clocked blocks so every register samples
  // pre-edge values; blocking here would create order-dependent simulation.
  // NOTE: this storage is reset even though EX rewrites it on first use,
  // so the values the EX block sees are never X after reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_o <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (we_i[k]) begin
          q_o[k] <= d_i[k];
        end
      end
    end
  end

endmodule

// File: rtl/vcve2_ex_seq.sv
// vcve2_ex_seq: execution-stage sequencer. Accepts one operation at a time from
// the decoder, drives the EX block's enables/selects/first-cycle flag, owns the
// intermediate-value registers, buffers the EX result for writeback, and
// supports flush and a watchdog abort.
//   RV32M          multiplier/divider config; RV32MNone forces mult/div selects low
//   TimeoutCycles  EXEC cycles allowed before abort (legal range 2..63)
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   bus            vcve2_ex_seq_if.slave: issue, EX control, intermediates,
//                  EX result, writeback and status signals
module vcve2_ex_seq
  import vcve2_pkg::*;
#(
  parameter rv32m_e      RV32M         = RV32MFast,
  parameter int unsigned TimeoutCycles = 40
) (
  input logic           clk_i,
  input logic           rst_ni,
  vcve2_ex_seq_if.slave bus
);

  localparam bit          MdEnabled   = (RV32M != RV32MNone);
  // The counter shows n-1 during EXEC cycle n, so the abort fires on this value.
  localparam ex_seq_cnt_t TimeoutLast = ex_seq_cnt_t'(TimeoutCycles - 1);

  ex_seq_state_e  state_q, state_d;
  logic           mult_sel_q, mult_sel_d;
  logic           div_sel_q, div_sel_d;
  ex_seq_cnt_t    cnt_q, cnt_d;
  ex_result_t     wb_result_q;
  imd_val_t [1:0] imd_q;

  logic in_exec;
  logic issue_ready;
  logic accept;
  logic ex_done;
  logic timeout;

  assign in_exec     = (state_q == EXEC);
  assign issue_ready = (state_q == IDLE) & ~bus.flush_i;
  assign accept      = bus.issue_valid_i & issue_ready;
  // Flush outranks both completion and the watchdog in the same cycle.
  assign ex_done     = in_exec & bus.ex_valid_i & ~bus.flush_i;
  assign timeout     = in_exec & ~bus.ex_valid_i & ~bus.flush_i & (cnt_q == TimeoutLast);

  // ---------------------------------------------------------------------------
  // FSM next state and class selects
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in this block gets a default first; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    state_d    = state_q;
    mult_sel_d = mult_sel_q;
    div_sel_d  = div_sel_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d    = EXEC;
          // Mult and div together is illegal and resolves to mult.
          mult_sel_d = MdEnabled & bus.issue_mult_i;
          div_sel_d  = MdEnabled & bus.issue_div_i & ~bus.issue_mult_i;
        end
      end
      EXEC: begin
        if (ex_done) begin
          state_d = WAIT_WB;
        end else if (timeout) begin
          state_d = IDLE;
        end
      end
      WAIT_WB: begin
        if (bus.wb_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (bus.flush_i) begin
      state_d = IDLE;
    end

    // Selects are only meaningful while an operation is in flight.
    if (state_d == IDLE) begin
      mult_sel_d = 1'b0;
      div_sel_d  = 1'b0;
    end
  end

  // EXEC-cycle counter: cleared on accept, counts every EXEC cycle, then holds
  // so the length of the last operation stays visible.
  always_comb begin
    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = '0;
    end else if (in_exec) begin
      cnt_d = sat_inc(cnt_q);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      mult_sel_q <= 1'b0;
      div_sel_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      mult_sel_q <= mult_sel_d;
      div_sel_q  <= div_sel_d;
      cnt_q      <= cnt_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wb_result_q <= '0;
    end else if (ex_done) begin
      wb_result_q <= bus.result_ex_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Intermediate-value registers: EX may only update them while executing.
  // ---------------------------------------------------------------------------
  vcve2_imd_val_reg u_imd_val_reg (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .we_i   (bus.imd_val_we_i & {2{in_exec}}),
    .d_i    (bus.imd_val_d_i),
    .q_o    (imd_q)
  );

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.issue_ready_o           = issue_ready;
  // Enables drop in the flush cycle itself so EX does no further work.
  assign bus.mult_en_o               = in_exec & mult_sel_q & ~bus.flush_i;
  assign bus.div_en_o                = in_exec & div_sel_q & ~bus.flush_i;
  assign bus.mult_sel_o              = mult_sel_q;
  assign bus.div_sel_o               = div_sel_q;
  assign bus.alu_instr_first_cycle_o = in_exec & (cnt_q == '0);
  assign bus.imd_val_q_o             = imd_q;
  assign bus.wb_valid_o              = (state_q == WAIT_WB);
  assign bus.wb_result_o             = wb_result_q;
  assign bus.exec_cycles_o           = cnt_q;
  assign bus.err_timeout_o           = timeout;

endmodule

// File: tb/tb_vcve2_ex_seq.sv
// tb_vcve2_ex_seq: self-checking bench for vcve2_ex_seq. A table of directed
// operations plus randomized operations are played through one instance
// (RV32MFast); a second instance (RV32MNone) covers the disabled-M case.
// Operation outcomes are predicted from the operation's parameters alone.
module tb_vcve2_ex_seq;
  import vcve2_pkg::*;

  localparam int TO = 40;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vcve2_ex_seq_if if0 ();
  vcve2_ex_seq_if if1 ();

  vcve2_ex_seq #(.RV32M(RV32MFast), .TimeoutCycles(TO)) u_dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (if0.slave)
  );

  vcve2_ex_seq #(.RV32M(RV32MNone), .TimeoutCycles(TO)) u_none (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (if1.slave)
  );

  int checks   = 0;
  int failures = 0;

  // Expected contents of if0's intermediate registers.
  imd_val_t [1:0] exp_imd = '0;

  // One operation: lat = EXEC cycle with ex_valid_i (0 = never), fl = EXEC
  // cycle with flush_i (0 = never), bp = cycles of wb_ready_i low.
  typedef struct {
    logic       m;
    logic       d;
    int         lat;
    int         fl;
    int         bp;
    ex_result_t res;
    logic       e_msel;
    logic       e_dsel;
    int         e_cycles;
    bit         e_wb;
    bit         e_to;
  } vec_t;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic imd_val_t rnd_imd();
    return imd_val_t'({$urandom(), $urandom()});
  endfunction

  function automatic vec_t mk(input logic m, input logic d, input int lat, input int fl,
                              input int bp, input ex_result_t res, input logic emsel,
                              input logic edsel, input int ecyc, input bit ewb, input bit eto);
    vec_t v;
    v.m = m; v.d = d; v.lat = lat; v.fl = fl; v.bp = bp; v.res = res;
    v.e_msel = emsel; v.e_dsel = edsel; v.e_cycles = ecyc; v.e_wb = ewb; v.e_to = eto;
    return v;
  endfunction

  // Reference outcome of an operation: whichever of result, flush or the
  // watchdog comes first ends it; flush wins a tie.
  function automatic vec_t model(input vec_t v);
    int end_n;
    bit flushed;
    end_n = TO;
    if (v.lat > 0 && v.lat < end_n) end_n = v.lat;
    if (v.fl > 0 && v.fl < end_n) end_n = v.fl;
    flushed    = (v.fl == end_n);
    v.e_wb     = !flushed && (v.lat == end_n);
    v.e_to     = !flushed && !v.e_wb;
    v.e_cycles = end_n;
    v.e_msel   = v.m;
    v.e_dsel   = v.d && !v.m;
    return v;
  endfunction

  task automatic idle_inputs();
    if0.issue_valid_i = 1'b0; if0.issue_mult_i = 1'b0; if0.issue_div_i = 1'b0;
    if0.flush_i = 1'b0; if0.imd_val_we_i = 2'b00; if0.imd_val_d_i = '0;
    if0.ex_valid_i = 1'b0; if0.result_ex_i = '0; if0.wb_ready_i = 1'b0;
  endtask

  task automatic idle_inputs1();
    if1.issue_valid_i = 1'b0; if1.issue_mult_i = 1'b0; if1.issue_div_i = 1'b0;
    if1.flush_i = 1'b0; if1.imd_val_we_i = 2'b00; if1.imd_val_d_i = '0;
    if1.ex_valid_i = 1'b0; if1.result_ex_i = '0; if1.wb_ready_i = 1'b0;
  endtask

  // Junk intermediate writes outside EXEC must be ignored.
  task automatic junk_imd();
    if0.imd_val_we_i = 2'b11;
    if0.imd_val_d_i  = {rnd_imd(), rnd_imd()};
  endtask

  task automatic run_op(input vec_t v, input string tag);
    int  n;
    int  to_seen;
    bit  done;
    logic [1:0] we;
    to_seen = 0;

    // Issue cycle (IDLE)
    @(posedge clk); #1;
    idle_inputs();
    if0.issue_valid_i = 1'b1; if0.issue_mult_i = v.m; if0.issue_div_i = v.d;
    junk_imd();
    @(negedge clk);
    check({tag, ":issue_ready"}, if0.issue_ready_o, 1'b1);
    check({tag, ":imd_idle"}, if0.imd_val_q_o, exp_imd);

    // EXEC cycles
    n = 0;
    done = 1'b0;
    while (!done) begin
      n++;
      @(posedge clk); #1;
      if0.issue_valid_i = 1'b0;
      if0.ex_valid_i    = (n == v.lat);
      if0.flush_i       = (n == v.fl);
      if0.result_ex_i   = (n == v.lat) ? v.res : ex_result_t'($urandom());
      we = 2'($urandom_range(0, 3));
      if0.imd_val_we_i  = we;
      if0.imd_val_d_i   = {rnd_imd(), rnd_imd()};
      @(negedge clk);
      check({tag, ":first"}, if0.alu_instr_first_cycle_o, (n == 1));
      check({tag, ":mult_en"}, if0.mult_en_o, v.e_msel && (n != v.fl));
      check({tag, ":div_en"}, if0.div_en_o, v.e_dsel && (n != v.fl));
      check({tag, ":mult_sel"}, if0.mult_sel_o, v.e_msel);
      check({tag, ":div_sel"}, if0.div_sel_o, v.e_dsel);
      check({tag, ":ready_exec"}, if0.issue_ready_o, 1'b0);
      check({tag, ":err_timeout"}, if0.err_timeout_o, (n == TO) && (n != v.lat) && (n != v.fl));
      check({tag, ":imd_exec"}, if0.imd_val_q_o, exp_imd);
      if (if0.err_timeout_o === 1'b1) to_seen++;
      for (int k = 0; k < 2; k++) if (we[k]) exp_imd[k] = if0.imd_val_d_i[k];
      done = (n == v.fl) || (n == v.lat) || (n >= TO);
    end

    @(posedge clk); #1;
    idle_inputs();
    junk_imd();

    if (v.e_wb) begin
      for (int b = 0; b <= v.bp; b++) begin
        if0.wb_ready_i = (b == v.bp);
        @(negedge clk);
        check({tag, ":wb_valid"}, if0.wb_valid_o, 1'b1);
        check({tag, ":wb_result"}, if0.wb_result_o, v.res);
        check({tag, ":ready_wb"}, if0.issue_ready_o, 1'b0);
        check({tag, ":en_wb"}, {if0.mult_en_o, if0.div_en_o}, 2'b00);
        check({tag, ":sel_wb"}, {if0.mult_sel_o, if0.div_sel_o}, {v.e_msel, v.e_dsel});
        check({tag, ":imd_wb"}, if0.imd_val_q_o, exp_imd);
        @(posedge clk); #1;
        junk_imd();
      end
      if0.wb_ready_i = 1'b0;
    end

    // Back in IDLE
    @(negedge clk);
    check({tag, ":ready_end"}, if0.issue_ready_o, 1'b1);
    check({tag, ":wb_valid_end"}, if0.wb_valid_o, 1'b0);
    check({tag, ":sel_end"}, {if0.mult_sel_o, if0.div_sel_o}, 2'b00);
    check({tag, ":exec_cycles"}, if0.exec_cycles_o, v.e_cycles);
    check({tag, ":timeouts"}, to_seen, v.e_to ? 1 : 0);
    check({tag, ":imd_end"}, if0.imd_val_q_o, exp_imd);
  endtask

  vec_t tbl[9];

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    vec_t v;
    tbl[0] = mk(0, 0,  1,  0, 0, 32'h1234_5678, 0, 0,  1, 1, 0);
    tbl[1] = mk(0, 1, 37,  0, 0, 32'h0BAD_D1F0, 0, 1, 37, 1, 0);
    tbl[2] = mk(0, 1,  0, 10, 0, 32'h0000_0000, 0, 1, 10, 0, 0);
    tbl[3] = mk(1, 0,  3,  0, 5, 32'hFEED_BEEF, 1, 0,  3, 1, 0);
    tbl[4] = mk(0, 0,  0,  0, 0, 32'h0000_0000, 0, 0, 40, 0, 1);
    tbl[5] = mk(1, 1,  2,  0, 1, 32'h5555_AAAA, 1, 0,  2, 1, 0);
    tbl[6] = mk(1, 0, 40,  0, 0, 32'h8000_0001, 1, 0, 40, 1, 0);
    tbl[7] = mk(0, 1,  5,  5, 0, 32'h0000_0001, 0, 1,  5, 0, 0);
    tbl[8] = mk(0, 0,  0, 40, 0, 32'h0000_0000, 0, 0, 40, 0, 0);

    idle_inputs();
    idle_inputs1();

    // Reset values
    #1;
    check("rst:issue_ready", if0.issue_ready_o, 1'b1);
    check("rst:outs", {if0.mult_en_o, if0.div_en_o, if0.mult_sel_o, if0.div_sel_o,
                       if0.alu_instr_first_cycle_o, if0.wb_valid_o, if0.err_timeout_o}, 7'b0);
    check("rst:imd", if0.imd_val_q_o, 68'b0);
    check("rst:wb_result", if0.wb_result_o, 32'b0);
    check("rst:exec_cycles", if0.exec_cycles_o, 6'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    foreach (tbl[i]) run_op(tbl[i], $sformatf("tbl%0d", i));

    // Flush blocks issue in IDLE; flush in WAIT_WB drops the result
    @(posedge clk); #1;
    idle_inputs();
    if0.issue_valid_i = 1'b1; if0.flush_i = 1'b1;
    @(negedge clk);
    check("fl_idle:issue_ready", if0.issue_ready_o, 1'b0);
    @(posedge clk); #1;
    if0.flush_i = 1'b0;
    @(negedge clk);
    check("fl_idle:still_idle", if0.issue_ready_o, 1'b1);
    check("fl_idle:no_first", if0.alu_instr_first_cycle_o, 1'b0);
    @(posedge clk); #1;
    if0.issue_valid_i = 1'b0; if0.ex_valid_i = 1'b1; if0.result_ex_i = 32'h0000_A5A5;
    @(negedge clk);
    check("fl_wb:first", if0.alu_instr_first_cycle_o, 1'b1);
    @(posedge clk); #1;
    if0.ex_valid_i = 1'b0; if0.flush_i = 1'b1;
    @(negedge clk);
    check("fl_wb:wb_valid", if0.wb_valid_o, 1'b1);
    check("fl_wb:wb_result", if0.wb_result_o, 32'h0000_A5A5);
    @(posedge clk); #1;
    if0.flush_i = 1'b0;
    @(negedge clk);
    check("fl_wb:wb_dropped", if0.wb_valid_o, 1'b0);
    check("fl_wb:ready", if0.issue_ready_o, 1'b1);

    // Randomized operations against the reference outcome
    for (int i = 0; i < 40; i++) begin
      v.m   = 1'($urandom_range(0, 1));
      v.d   = 1'($urandom_range(0, 1));
      v.lat = $urandom_range(0, 45);
      v.fl  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 45) : 0;
      v.bp  = $urandom_range(0, 3);
      v.res = ex_result_t'($urandom());
      run_op(model(v), $sformatf("rnd%0d", i));
    end

    // Reset in the middle of a div with live intermediates
    @(posedge clk); #1;
    idle_inputs();
    if0.issue_valid_i = 1'b1; if0.issue_div_i = 1'b1;
    @(posedge clk); #1;
    idle_inputs();
    if0.imd_val_we_i = 2'b11; if0.imd_val_d_i = {34'h3_FFFF_FFFF, 34'h2_AAAA_5555};
    @(posedge clk); #1;
    if0.imd_val_we_i = 2'b00;
    @(negedge clk);
    check("mid_rst:pre_div_en", if0.div_en_o, 1'b1);
    check("mid_rst:pre_imd", if0.imd_val_q_o, {34'h3_FFFF_FFFF, 34'h2_AAAA_5555});
    rst_n = 1'b0;
    #1;
    check("mid_rst:issue_ready", if0.issue_ready_o, 1'b1);
    check("mid_rst:outs", {if0.div_en_o, if0.div_sel_o, if0.wb_valid_o,
                           if0.alu_instr_first_cycle_o}, 4'b0);
    check("mid_rst:imd", if0.imd_val_q_o, 68'b0);
    check("mid_rst:exec_cycles", if0.exec_cycles_o, 6'b0);
    exp_imd = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst:no_wb", if0.wb_valid_o, 1'b0);

    // RV32MNone: a mult request runs as an ALU op
    @(posedge clk); #1;
    idle_inputs1();
    if1.issue_valid_i = 1'b1; if1.issue_mult_i = 1'b1;
    @(negedge clk);
    check("none:issue_ready", if1.issue_ready_o, 1'b1);
    @(posedge clk); #1;
    if1.issue_valid_i = 1'b0; if1.issue_mult_i = 1'b0;
    @(negedge clk);
    check("none:first", if1.alu_instr_first_cycle_o, 1'b1);
    check("none:mult_sel", if1.mult_sel_o, 1'b0);
    check("none:mult_en", if1.mult_en_o, 1'b0);
    @(posedge clk); #1;
    if1.ex_valid_i = 1'b1; if1.result_ex_i = 32'hCAFE_0001;
    @(negedge clk);
    check("none:mult_en2", if1.mult_en_o, 1'b0);
    @(posedge clk); #1;
    if1.ex_valid_i = 1'b0; if1.wb_ready_i = 1'b1;
    @(negedge clk);
    check("none:wb_valid", if1.wb_valid_o, 1'b1);
    check("none:wb_result", if1.wb_result_o, 32'hCAFE_0001);
    check("none:mult_sel_wb", if1.mult_sel_o, 1'b0);
    @(posedge clk); #1;
    if1.wb_ready_i = 1'b0;
    @(negedge clk);
    check("none:idle", {if1.wb_valid_o, if1.issue_ready_o}, 2'b01);
    check("none:exec_cycles", if1.exec_cycles_o, 6'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
